// File: rtl/rr_fifo_wr_arbiter.sv
// Round-robin write arbiter: funnels NREQ valid/ready sources into one
// synchronous FIFO write port. A grant lasts up to MAXBURST beats, ends early
// when the granted source drops valid, and holds through FIFO-full stalls.
// Each FIFO word carries the source index above the payload.
module rr_fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 8,
  parameter int MAXBURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*DATAWIDTH-1:0]     req_data,
  output logic [NREQ-1:0]               req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATAWIDTH+$clog2(NREQ)-1:0] fifo_din,
  output logic [$clog2(NREQ)-1:0]       grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int BCW = 4;  // holds 0..MAXBURST for MAXBURST up to 15

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [IDW-1:0]   last_ptr_q, last_ptr_d;
  logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;

  logic             sel_found;
  logic [IDW-1:0]   sel_id;
  logic             gnt_valid;
  logic [DATAWIDTH-1:0] gnt_data;
  logic             xfer;
  logic             fire;

  // Round-robin pick: first valid source after last_ptr, wrapping around.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_ptr_q) + k) % NREQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(idx);
      end
    end
  end

  // Select the valid bit and payload of the currently granted source.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        gnt_valid = req_valid[i];
        gnt_data  = req_data[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Next-state logic: arbitration in IDLE, beat counting and release in GRANT.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    last_ptr_d = last_ptr_q;
    xfer       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_id_d = sel_id;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!gnt_valid) begin
          // Source went quiet: release without a transfer this cycle.
          state_d    = IDLE;
          last_ptr_d = grant_id_q;
        end else if (!fifo_full) begin
          xfer       = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BCW'(MAXBURST - 1)) begin
            state_d    = IDLE;
            last_ptr_d = grant_id_q;
          end
        end
        // Valid but FIFO full: hold the grant and the beat count.
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; requester 0 wins first arbitration.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      last_ptr_q <= IDW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  // Transfer outputs are combinational (zero-latency accept-to-write) and
  // masked by reset so an aborted burst never writes in the reset cycle.
  assign fire       = xfer & ~reset;
  assign fifo_wr_en = fire;
  assign req_ready  = fire ? (NREQ'(1) << grant_id_q) : '0;
  assign fifo_din   = fire ? {grant_id_q, gnt_data} : '0;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == GRANT) & ~reset;

endmodule

// File: tb/tb_rr_fifo_wr_arbiter.sv
// Self-checking bench for rr_fifo_wr_arbiter. Each source is a queue of
// payloads; expected FIFO words are pushed to a scoreboard when stimulus is
// loaded and popped by the monitor on every observed write.
module tb_rr_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [DW+IDW-1:0]    fifo_din;
  logic [IDW-1:0]       grant_id;
  logic                 busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int hs_total     = 0;
  int wr_total     = 0;

  logic [DW+IDW-1:0] sb [$];
  logic [DW-1:0]     src [NREQ][$];
  int                wr_cycles [$];
  logic [NREQ-1:0]   hs_q = '0;

  rr_fifo_wr_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .MAXBURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [DW+IDW-1:0] word(input int id, input int data);
    return {IDW'(id), DW'(data)};
  endfunction

  function automatic bit src_pending();
    for (int i = 0; i < NREQ; i++)
      if (src[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Source model: retire accepted payloads, present the next one.
  task automatic drive_sources();
    for (int i = 0; i < NREQ; i++) begin
      if (hs_q[i] && src[i].size() != 0) void'(src[i].pop_front());
      req_valid[i]         = (src[i].size() != 0);
      req_data[i*DW +: DW] = (src[i].size() != 0) ? src[i][0] : '0;
    end
    hs_q = '0;
  endtask

  // Per-cycle invariants plus scoreboard comparison of each FIFO write.
  task automatic monitor_cycle();
    logic [DW+IDW-1:0] exp_w;
    hs_q = req_valid & req_ready;
    hs_total += $countones(hs_q);
    tests_run++;
    if (!$onehot0(req_ready)) begin
      tests_failed++;
      $display("FAIL ready_onehot: req_ready=%b, required one-hot or zero", req_ready);
    end
    tests_run++;
    if (fifo_wr_en && fifo_full) begin
      tests_failed++;
      $display("FAIL wr_while_full: fifo_wr_en=1 with fifo_full=1 at cycle %0d", cyc);
    end
    tests_run++;
    if (fifo_wr_en !== (|hs_q)) begin
      tests_failed++;
      $display("FAIL wr_vs_handshake: fifo_wr_en=%b, handshake=%b", fifo_wr_en, hs_q);
    end
    tests_run++;
    if (!fifo_wr_en && fifo_din !== '0) begin
      tests_failed++;
      $display("FAIL din_idle_zero: fifo_din=%h, required 0", fifo_din);
    end
    tests_run++;
    if ((req_ready & ~(4'b0001 << grant_id)) !== '0) begin
      tests_failed++;
      $display("FAIL ready_lane: req_ready=%b, grant_id=%0d", req_ready, grant_id);
    end
    if (fifo_wr_en) begin
      wr_total++;
      wr_cycles.push_back(cyc);
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: fifo_din=%h, scoreboard empty", fifo_din);
      end else begin
        exp_w = sb.pop_front();
        if (fifo_din !== exp_w) begin
          tests_failed++;
          $display("FAIL fifo_word: got %h, expected %h", fifo_din, exp_w);
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      drive_sources();
    end
  end

  initial forever begin
    @(negedge clk);
    monitor_cycle();
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) src[i].delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wr_cycles.delete();
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int n = 0;
    while ((sb.size() != 0 || busy || src_pending()) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (n >= max_cycles) begin
      tests_failed++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles", name, sb.size(), n);
    end
  endtask

  task automatic wait_writes(input int count, input int max_cycles, input string name);
    int n = 0;
    while (wr_cycles.size() < count && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (n >= max_cycles) begin
      tests_failed++;
      $display("FAIL %s_timeout: saw %0d writes, waited for %0d", name, wr_cycles.size(), count);
    end
  endtask

  task automatic test_reset();
    src[0].push_back(8'hA5);
    src[0].push_back(8'h5A);
    sb.push_back(word(0, 8'hA5));
    sb.push_back(word(0, 8'h5A));
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (fifo_wr_en !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || fifo_din !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs: wr_en=%b ready=%b busy=%b din=%h, required all 0",
                 fifo_wr_en, req_ready, busy, fifo_din);
      end
      tests_run++;
      if (grant_id !== '0) begin
        tests_failed++;
        $display("FAIL reset_grant_id: got %0d, required 0", grant_id);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (fifo_wr_en !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || fifo_din !== '0) begin
      tests_failed++;
      $display("FAIL post_reset_outputs: wr_en=%b ready=%b busy=%b din=%h, required all 0",
               fifo_wr_en, req_ready, busy, fifo_din);
    end
    wait_drain(40, "reset");
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      src[2].push_back(DW'(8'h10 + k));
      sb.push_back(word(2, 8'h10 + k));
    end
    wait_drain(60, "single");
    tests_run++;
    if (wr_cycles.size() != 8) begin
      tests_failed++;
      $display("FAIL single_count: got %0d writes, required 8", wr_cycles.size());
    end else begin
      tests_run++;
      if (wr_cycles[7] - wr_cycles[0] != 8) begin
        tests_failed++;
        $display("FAIL single_span: got %0d cycles first-to-last, required 8",
                 wr_cycles[7] - wr_cycles[0]);
      end
      tests_run++;
      if (wr_cycles[4] - wr_cycles[3] != 2) begin
        tests_failed++;
        $display("FAIL single_gap: got %0d, required 2 (one IDLE cycle)",
                 wr_cycles[4] - wr_cycles[3]);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 2*MB; k++) src[i].push_back(DW'(i*32 + k));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        for (int k = 0; k < MB; k++) sb.push_back(word(i, i*32 + r*MB + k));
    wait_drain(200, "round_robin");
    tests_run++;
    if (wr_cycles.size() != 32) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d writes, required 32", wr_cycles.size());
    end else begin
      tests_run++;
      if (wr_cycles[31] - wr_cycles[0] != 38) begin
        tests_failed++;
        $display("FAIL rr_throughput: got span %0d, required 38", wr_cycles[31] - wr_cycles[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      src[1].push_back(DW'(8'h40 + k));
      sb.push_back(word(1, 8'h40 + k));
    end
    wait_writes(2, 20, "bp_beat2");
    #1;
    fifo_full = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      tests_run++;
      if (fifo_wr_en !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_stall: wr_en=%b ready=%b busy=%b, required 0,0000,1",
                 fifo_wr_en, req_ready, busy);
      end
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    wait_writes(4, 20, "bp_beat4");
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: busy=%b wr_en=%b after beat 4, required IDLE", busy, fifo_wr_en);
    end
    tests_run++;
    if (wr_cycles.size() < 3 || wr_cycles[2] - wr_cycles[1] != 4) begin
      tests_failed++;
      $display("FAIL bp_stall_len: beat2->beat3 gap wrong, writes=%0d", wr_cycles.size());
    end
    wait_drain(40, "backpressure");
  endtask

  task automatic test_early_drop();
    do_reset();
    src[2].push_back(8'h80);
    sb.push_back(word(2, 8'h80));
    wait_drain(20, "drop_setup");
    wr_cycles.delete();
    src[3].push_back(8'h90);
    src[0].push_back(8'hA0);
    src[0].push_back(8'hA1);
    sb.push_back(word(3, 8'h90));
    sb.push_back(word(0, 8'hA0));
    sb.push_back(word(0, 8'hA1));
    wait_drain(40, "early_drop");
    tests_run++;
    if (wr_cycles.size() != 3 || wr_cycles[1] - wr_cycles[0] != 3) begin
      tests_failed++;
      $display("FAIL drop_gap: writes=%0d, required 3 writes with 3-cycle drop gap",
               wr_cycles.size());
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      src[1].push_back(DW'(8'h50 + k));
      sb.push_back(word(1, 8'h50 + k));
    end
    wait_drain(30, "mid_reset_setup");
    wr_cycles.delete();
    for (int k = 0; k < 4; k++) src[2].push_back(DW'(8'h60 + k));
    sb.push_back(word(2, 8'h60));
    wait_writes(1, 20, "mid_reset_beat1");
    #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      src[1].push_back(DW'(8'h54 + k));
      src[3].push_back(DW'(8'h70 + k));
    end
    for (int k = 0; k < 4; k++) sb.push_back(word(1, 8'h54 + k));
    for (int k = 1; k < 4; k++) sb.push_back(word(2, 8'h60 + k));
    for (int k = 0; k < 4; k++) sb.push_back(word(3, 8'h70 + k));
    @(negedge clk);
    tests_run++;
    if (fifo_wr_en !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || fifo_din !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_abort: wr_en=%b ready=%b busy=%b din=%h, required all 0",
               fifo_wr_en, req_ready, busy, fifo_din);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (fifo_wr_en !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || fifo_din !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_idle: wr_en=%b ready=%b busy=%b din=%h, required all 0",
               fifo_wr_en, req_ready, busy, fifo_din);
    end
    wait_drain(100, "mid_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_drop();
    test_mid_reset();
    repeat (2) @(posedge clk);
    tests_run++;
    if (wr_total != hs_total) begin
      tests_failed++;
      $display("FAIL write_count: %0d writes, %0d handshakes", wr_total, hs_total);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rr_fifo_wr_arbiter.md
RR_FIFO_WR_ARBITER -- requirements
Module: rr_fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter DATAWIDTH, default 8, meaning payload width per requester.
REQ-003 SHALL have parameter MAXBURST, default 4, meaning maximum beats per grant (1..15).
REQ-004 SHALL define IDW = $clog2(NREQ) as a localparam.
REQ-005 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  NREQ  per-requester data valid.
REQ-008 SHALL have port req_data  input  NREQ*DATAWIDTH  payloads; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
REQ-009 SHALL have port req_ready  output  NREQ  per-requester accept strobe.
REQ-010 SHALL have port fifo_full  input  1  full flag of the downstream sync FIFO.
REQ-011 SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-012 SHALL have port fifo_din  output  DATAWIDTH+IDW  FIFO write word: {grant_id, payload}.
REQ-013 SHALL have port grant_id  output  IDW  requester currently granted.
REQ-014 SHALL have port busy  output  1  high while in GRANT state.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-016 IDLE: if any req_valid is high, SHALL select the first valid requester searching from (last_ptr+1) mod NREQ upward with wrap, load grant_id, clear beat_cnt, and enter GRANT next cycle; no transfer occurs in IDLE.
REQ-017 IDLE with no req_valid: SHALL remain in IDLE; grant_id holds its value.
REQ-018 A beat transfers in GRANT when req_valid[grant_id]=1 and fifo_full=0.
REQ-019 Transfer beat: fifo_wr_en=1, req_ready[grant_id]=1, fifo_din={grant_id, req_data slice of grant_id}, all combinationally in the same cycle; latency from accept to FIFO write is 0 cycles.
REQ-020 req_ready SHALL be one-hot or zero; req_ready of non-granted requesters SHALL always be 0.
REQ-021 fifo_wr_en SHALL never be high when fifo_full=1 or the FSM is in IDLE.
REQ-022 beat_cnt SHALL increment by 1 on each transfer beat; full-stall cycles do not count.
REQ-023 GRANT -> IDLE when a transfer beat brings beat_cnt to MAXBURST; last_ptr <= grant_id.
REQ-024 GRANT -> IDLE when req_valid[grant_id]=0 (no transfer that cycle); last_ptr <= grant_id.
REQ-025 GRANT with req_valid[grant_id]=1 and fifo_full=1: SHALL stay in GRANT, hold beat_cnt, drive fifo_wr_en=0 and req_ready=0.
REQ-026 Arbitration overhead SHALL be exactly one IDLE cycle between grants; maximum throughput is MAXBURST beats per MAXBURST+1 cycles.
REQ-027 A requester that loses the grant SHALL not be re-granted while another requester's valid is high at the next arbitration (strict round-robin fairness).
REQ-028 fifo_din SHALL be 0 whenever fifo_wr_en=0.

Reset
REQ-029 On reset: state=IDLE, grant_id=0, beat_cnt=0, last_ptr=NREQ-1 (so requester 0 has first priority).
REQ-030 During and in the cycle after reset: fifo_wr_en=0, req_ready=0, busy=0, fifo_din=0.
REQ-031 Reset asserted mid-burst SHALL abort the grant immediately; no partial-state beat is written in the reset cycle.

Verification
REQ-032 Single requester: req_valid=4'b0100 continuously, data 0x10..0x17, fifo_full=0 -> writes {2,0x10..0x13}, one IDLE cycle, then {2,0x14..0x17}; 8 writes in 10 cycles.
REQ-033 All four valid after reset, full=0 -> grant order 0,1,2,3,0; each grant 4 beats; fifo_din[9:8] follows that order.
REQ-034 Backpressure: requester 1 granted, fifo_full=1 for 3 cycles after beat 2 -> no writes, req_ready=0, beat_cnt holds at 2; beats 3 and 4 written after full drops, then IDLE.
REQ-035 Early drop: requester 3 drops valid after 1 beat while requester 0 valid -> GRANT->IDLE, next grant_id=0, last_ptr=3.
REQ-036 Reset mid-burst: reset high during beat 2 of requester 2 -> next cycle state IDLE, all outputs 0, next grant goes to lowest valid index starting at 0.
REQ-037 Assertions always on: req_ready one-hot-or-zero, no fifo_wr_en while fifo_full=1, write count equals sum of req_valid&req_ready handshakes.
